// File: rtl/adau1761_pkg.sv
// Shared types and constants for the ADAU1761 SPI configurator arbiter.
package adau1761_pkg;

  localparam int ADAU_ADDR_W = 16;
  localparam int ADAU_DATA_W = 8;
  localparam logic [7:0] ADAU_CMD_WRITE = 8'h00;
  localparam logic [7:0] ADAU_CMD_READ  = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_RESPOND    = 3'd4,
    ST_GAP        = 3'd5
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  function automatic int wrap_idx(input int p, input int k);
    return (p + k) % NUM_REQ;
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && req[wrap_idx(int'(ptr), k)]) begin
        grant_any                       = 1'b1;
        grant[wrap_idx(int'(ptr), k)]   = 1'b1;
        grant_idx                       = IDX_W'(wrap_idx(int'(ptr), k));
      end
    end
  end

endmodule

// File: rtl/adau1761_spi_arbiter.sv
// Round-robin sharing of one ADAU1761 SPI configurator among NUM_REQ requesters.
// Optional watchdog enabled by defining ADAU_ARB_TIMEOUT_EN.
module adau1761_spi_arbiter
  import adau1761_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_rnw,
  input  logic [NUM_REQ*ADAU_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*ADAU_DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [ADAU_DATA_W-1:0]         rsp_rdata,
  output logic                           rsp_err,
  output logic                           cfg_write,
  output logic                           cfg_read,
  output logic [ADAU_ADDR_W-1:0]         cfg_address,
  output logic [ADAU_DATA_W-1:0]         cfg_write_value,
  input  logic [39:0]                    cfg_read_value,
  input  logic                           cfg_cs,
  output logic [2:0]                     dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  arb_state_t         state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   arb_idx;
  logic [NUM_REQ-1:0] arb_grant;
  logic [NUM_REQ-1:0] grant_q;
  logic               arb_any;
  logic               rnw_q;
  logic               wd_hit;
  logic [GAP_W-1:0]   gap_cnt;
  logic               unused_rv;

  assign dbg_state = state;
  assign unused_rv = ^cfg_read_value[39:8];

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

`ifdef ADAU_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // Zero during ISSUE, so a hit in WAIT_* yields the response TIMEOUT_CYCLES after ISSUE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt <= '0;
    end else if (state == ST_ISSUE || state == ST_WAIT_START || state == ST_WAIT_DONE) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

  assign wd_hit = (wd_cnt >= WD_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign wd_hit         = 1'b0;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  // Handshake: a requester holds req_valid (and its command) until it sees its
  // req_ready pulse; rsp_valid/rsp_rdata/rsp_err are a single-cycle pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= ST_IDLE;
      ptr             <= '0;
      grant_q         <= '0;
      rnw_q           <= 1'b0;
      gap_cnt         <= '0;
      req_ready       <= '0;
      rsp_valid       <= '0;
      rsp_rdata       <= '0;
      rsp_err         <= 1'b0;
      cfg_write       <= 1'b0;
      cfg_read        <= 1'b0;
      cfg_address     <= '0;
      cfg_write_value <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      cfg_write <= 1'b0;
      cfg_read  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            grant_q         <= arb_grant;
            rnw_q           <= req_rnw[arb_idx];
            cfg_address     <= req_addr[arb_idx*ADAU_ADDR_W +: ADAU_ADDR_W];
            cfg_write_value <= req_wdata[arb_idx*ADAU_DATA_W +: ADAU_DATA_W];
            req_ready       <= arb_grant;
            ptr             <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            state           <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cfg_read  <= rnw_q;
          cfg_write <= !rnw_q;
          state     <= ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (!cfg_cs) begin
            state <= ST_WAIT_DONE;
          end else if (wd_hit) begin
            rsp_valid <= grant_q;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state     <= ST_RESPOND;
          end
        end
        ST_WAIT_DONE: begin
          if (cfg_cs) begin
            rsp_valid <= grant_q;
            rsp_rdata <= rnw_q ? cfg_read_value[ADAU_DATA_W-1:0] : '0;
            rsp_err   <= 1'b0;
            state     <= ST_RESPOND;
          end else if (wd_hit) begin
            rsp_valid <= grant_q;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state     <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          gap_cnt   <= '0;
          state     <= ST_GAP;
        end
        ST_GAP: begin
          // Only cycles with chip select released count towards the gap.
          if (cfg_cs) begin
            if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
              gap_cnt <= '0;
              state   <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end else begin
            gap_cnt <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adau1761_spi_arbiter.sv
// Directed bench for adau1761_spi_arbiter with a cycle model of the SPI configurator.
module tb_adau1761_spi_arbiter;

  localparam int NUM_REQ = 4;
  localparam int GAP     = 4;
  localparam int TO      = 256;
  localparam int LIM     = 300;

  logic        clk;
  logic        resetn;
  logic [3:0]  req_valid;
  logic [3:0]  req_rnw;
  logic [63:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        cfg_write;
  logic        cfg_read;
  logic [15:0] cfg_address;
  logic [7:0]  cfg_write_value;
  logic [39:0] cfg_read_value;
  logic        cfg_cs;
  logic [2:0]  dbg_state;

  int          n_checks = 0;
  int          n_fail   = 0;

  logic        m_rnw[4];
  logic [15:0] m_addr[4];
  logic [7:0]  m_wdata[4];

  logic [7:0]  model_rdata;
  bit          model_hang;
  int          cs_cnt;
  int          hi_run;
  int          last_gap;

  adau1761_spi_arbiter #(.NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .req_valid       (req_valid),
    .req_rnw         (req_rnw),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .cfg_write       (cfg_write),
    .cfg_read        (cfg_read),
    .cfg_address     (cfg_address),
    .cfg_write_value (cfg_write_value),
    .cfg_read_value  (cfg_read_value),
    .cfg_cs          (cfg_cs),
    .dbg_state       (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // Configurator model: cs drops the cycle after a strobe and stays low ~32 cycles.
  assign cfg_read_value = {32'hDEADBEEF, model_rdata};

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cfg_cs <= 1'b1;
      cs_cnt <= 0;
    end else if (cs_cnt > 0) begin
      cs_cnt <= cs_cnt - 1;
      if (cs_cnt == 1) cfg_cs <= 1'b1;
    end else if ((cfg_write || cfg_read) && !model_hang) begin
      cfg_cs <= 1'b0;
      cs_cnt <= 32;
    end
  end

  // Cycles of cs high seen before each strobe
  always @(negedge clk) begin
    if (cfg_write || cfg_read) last_gap <= hi_run;
    hi_run <= cfg_cs ? hi_run + 1 : 0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver
  task automatic add_req(input int i, input logic rnw, input logic [15:0] a, input logic [7:0] d);
    m_rnw[i]            = rnw;
    m_addr[i]           = a;
    m_wdata[i]          = d;
    req_rnw[i]          = rnw;
    req_addr[16*i +: 16] = a;
    req_wdata[8*i +: 8]  = d;
    req_valid[i]        = 1'b1;
  endtask

  task automatic run_txn(input int g, input int exp_lat, input logic [7:0] exp_rd, input bit allow_idle);
    int   n;
    logic p1;
    logic p2;
    logic rnw_e;
    rnw_e = m_rnw[g];
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == 4'b0 && n < LIM);
    check("req_ready", 64'(req_ready), 64'd1 << g);
    if (exp_lat != 0) check("ready_latency", 64'(n), 64'(exp_lat));
    req_valid[g] = 1'b0;
    @(negedge clk);
    check("strobe_kind", {62'b0, cfg_read, cfg_write}, rnw_e ? 64'd2 : 64'd1);
    check("cfg_address", 64'(cfg_address), 64'(m_addr[g]));
    if (!rnw_e) check("cfg_write_value", 64'(cfg_write_value), 64'(m_wdata[g]));
    @(negedge clk);
    check("strobe_width", {62'b0, cfg_read, cfg_write}, 64'd0);
    p1 = 1'b0;
    p2 = 1'b0;
    n  = 0;
    while (rsp_valid == 4'b0 && n < LIM) begin
      p2 = p1;
      p1 = cfg_cs;
      @(negedge clk);
      n++;
    end
    check("rsp_valid", 64'(rsp_valid), 64'd1 << g);
    check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
    check("rsp_err", 64'(rsp_err), 64'd0);
    check("rsp_after_cs_rise", {62'b0, p2, p1}, 64'd1);
    check("addr_held", 64'(cfg_address), 64'(m_addr[g]));
    @(negedge clk);
    check("rsp_pulse", 64'(rsp_valid), 64'd0);
    if (allow_idle && req_valid == 4'b0) repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  add_mask;
    logic        rnw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          exp_g;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int n;
    int g;
    int seen;

    // add_mask, rnw, addr base (+i), wdata base (+i), model rdata, expected grant, ready latency
    vecs[0]  = '{4'b0001, 1'b0, 16'h4000, 8'h01, 8'h00, 0, 1};
    vecs[1]  = '{4'b1000, 1'b0, 16'h4100, 8'h11, 8'h00, 3, 1};
    vecs[2]  = '{4'b1111, 1'b0, 16'h4010, 8'h20, 8'h00, 0, 1};
    vecs[3]  = '{4'b0000, 1'b0, 16'h0000, 8'h00, 8'h00, 1, 0};
    vecs[4]  = '{4'b0000, 1'b0, 16'h0000, 8'h00, 8'h00, 2, 0};
    vecs[5]  = '{4'b0000, 1'b0, 16'h0000, 8'h00, 8'h00, 3, 0};
    vecs[6]  = '{4'b1001, 1'b1, 16'h4020, 8'h00, 8'h77, 0, 1};
    vecs[7]  = '{4'b0000, 1'b0, 16'h0000, 8'h00, 8'h3C, 3, 0};
    vecs[8]  = '{4'b0100, 1'b1, 16'h4017, 8'h00, 8'h03, 2, 1};
    vecs[9]  = '{4'b0110, 1'b0, 16'h40F0, 8'hA0, 8'h00, 1, 1};
    vecs[10] = '{4'b0000, 1'b0, 16'h0000, 8'h00, 8'h00, 2, 0};

    resetn      = 1'b0;
    req_valid   = '0;
    req_rnw     = '0;
    req_addr    = '0;
    req_wdata   = '0;
    model_rdata = 8'h00;
    model_hang  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_rnw[i]   = 1'b0;
      m_addr[i]  = '0;
      m_wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {13'b0, req_ready, rsp_valid, rsp_rdata, rsp_err, cfg_write, cfg_read, cfg_address, cfg_write_value},
          64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Table-driven transactions: single write, round-robin order, wrap, reads
    for (int r = 0; r < 11; r++) begin
      model_rdata = vecs[r].rdata;
      for (int i = 0; i < 4; i++) begin
        if (vecs[r].add_mask[i]) add_req(i, vecs[r].rnw, vecs[r].addr + 16'(i), vecs[r].wdata + 8'(i));
      end
      g = vecs[r].exp_g;
      run_txn(g, vecs[r].exp_lat, m_rnw[g] ? vecs[r].rdata : 8'h00, 1'b1);
    end

    // Configurator never lowers cs
    model_hang = 1'b1;
    add_req(0, 1'b0, 16'h4030, 8'h55);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == 4'b0 && n < LIM);
    check("hang_req_ready", 64'(req_ready), 64'd1);
    req_valid[0] = 1'b0;
`ifdef ADAU_ARB_TIMEOUT_EN
    n = 0;
    while (rsp_valid == 4'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", 64'(n), 64'(TO));
    check("timeout_rsp_valid", 64'(rsp_valid), 64'd1);
    check("timeout_rsp_err", 64'(rsp_err), 64'd1);
    check("timeout_rsp_rdata", 64'(rsp_rdata), 64'd0);
`else
    seen = 0;
    repeat (1000) begin
      @(negedge clk);
      if (rsp_valid != 4'b0) seen++;
    end
    check("no_rsp_without_watchdog", 64'(seen), 64'd0);
`endif
    model_hang = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of WAIT_DONE drops the transaction
    add_req(2, 1'b1, 16'h4050, 8'h00);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == 4'b0 && n < LIM);
    check("mid_req_ready", 64'(req_ready), 64'd4);
    req_valid[2] = 1'b0;
    n = 0;
    while (cfg_cs && n < LIM) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("mid_in_wait_done", 64'(dbg_state), 64'd3);
    resetn = 1'b0;
    #1;
    check("async_reset_outputs",
          {13'b0, req_ready, rsp_valid, rsp_rdata, rsp_err, cfg_write, cfg_read, cfg_address, cfg_write_value},
          64'd0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid != 4'b0) seen++;
    end
    check("no_rsp_in_reset", 64'(seen), 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    add_req(1, 1'b0, 16'h4060, 8'h66);
    run_txn(1, 1, 8'h00, 1'b1);

    // Back-to-back writes from one requester honour the idle gap
    add_req(1, 1'b0, 16'h4070, 8'h70);
    run_txn(1, 1, 8'h00, 1'b0);
    add_req(1, 1'b0, 16'h4071, 8'h71);
    run_txn(1, 0, 8'h00, 1'b1);
    n_checks++;
    if (last_gap < GAP + 3) begin
      n_fail++;
      $display("FAIL gap_cycles: got %0d cs-high cycles before strobe, need at least %0d", last_gap, GAP + 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
